// File: rtl/alu_accum_seq.sv
// Sequential accumulate ALU: a job seeds the accumulator, folds in a stream of
// operands with a fixed opcode, then presents the final value until it is taken.
module alu_accum_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       opcode,
    input  logic [WIDTH-1:0] init,
    input  logic [3:0]       len,
    input  logic             op_valid,
    input  logic [WIDTH-1:0] op_data,
    output logic             op_ready,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             res_carry,
    output logic             res_zero,
    input  logic             res_ready,
    output logic             busy
);

    localparam logic [1:0] OpAnd = 2'b00;
    localparam logic [1:0] OpXor = 2'b01;
    localparam logic [1:0] OpAdd = 2'b10;
    localparam logic [1:0] OpSub = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [3:0]       remCount_q, remCount_d;
    logic [1:0]       opcode_q, opcode_d;

    logic             startAccept;
    logic             opAccept;
    logic             lastAccept;
    logic             resHandshake;
    logic [WIDTH-1:0] aluResult;
    logic             aluCarry;
    logic [WIDTH:0]   sumExt;
    logic [WIDTH:0]   diffExt;

    assign startAccept  = (state_q == IDLE) && start;
    assign opAccept     = (state_q == RUN) && op_valid;
    assign lastAccept   = opAccept && (remCount_q == 4'd1);
    assign resHandshake = (state_q == DONE) && res_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (len != 4'd0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (lastAccept) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (resHandshake) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Result fields are gated so they read zero outside DONE, matching the reset view.
    always_comb begin
        op_ready  = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b0;
        res_data  = '0;
        res_carry = 1'b0;
        res_zero  = 1'b0;
        unique case (state_q)
            RUN: begin
                op_ready = 1'b1;
                busy     = 1'b1;
            end
            DONE: begin
                res_valid = 1'b1;
                busy      = 1'b1;
                res_data  = acc_q;
                res_carry = carry_q;
                res_zero  = (acc_q == '0);
            end
            default: begin
                op_ready = 1'b0;
            end
        endcase
    end

    // Borrow for SUB falls out of the extended difference's top bit (acc < op_data).
    always_comb begin
        sumExt    = {1'b0, acc_q} + {1'b0, op_data};
        diffExt   = {1'b0, acc_q} - {1'b0, op_data};
        aluResult = '0;
        aluCarry  = 1'b0;
        unique case (opcode_q)
            OpAnd: aluResult = acc_q & op_data;
            OpXor: aluResult = acc_q ^ op_data;
            OpAdd: begin
                aluResult = sumExt[WIDTH-1:0];
                aluCarry  = sumExt[WIDTH];
            end
            OpSub: begin
                aluResult = diffExt[WIDTH-1:0];
                aluCarry  = diffExt[WIDTH];
            end
            default: aluResult = '0;
        endcase
    end

    always_comb begin
        acc_d      = acc_q;
        carry_d    = carry_q;
        remCount_d = remCount_q;
        opcode_d   = opcode_q;
        if (startAccept) begin
            acc_d      = init;
            carry_d    = 1'b0;
            remCount_d = len;
            opcode_d   = opcode;
        end else if (opAccept) begin
            acc_d      = aluResult;
            carry_d    = aluCarry;
            remCount_d = remCount_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            carry_q    <= 1'b0;
            remCount_q <= 4'd0;
            opcode_q   <= OpAnd;
        end else begin
            acc_q      <= acc_d;
            carry_q    <= carry_d;
            remCount_q <= remCount_d;
            opcode_q   <= opcode_d;
        end
    end

endmodule

// File: tb/tb_alu_accum_seq.sv
// Self-checking bench for alu_accum_seq: directed jobs plus random jobs compared
// against an arithmetic reference model, with mid-job reset and ignored-start cases.
module tb_alu_accum_seq;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [1:0]       opcode;
    logic [WIDTH-1:0] init;
    logic [3:0]       len;
    logic             op_valid;
    logic [WIDTH-1:0] op_data;
    logic             op_ready;
    logic             res_valid;
    logic [WIDTH-1:0] res_data;
    logic             res_carry;
    logic             res_zero;
    logic             res_ready;
    logic             busy;

    int errors = 0;
    int checks = 0;
    int opsArr [16];
    int lastObsData;
    int lastObsCarry;
    int lastObsZero;

    alu_accum_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .opcode    (opcode),
        .init      (init),
        .len       (len),
        .op_valid  (op_valid),
        .op_data   (op_data),
        .op_ready  (op_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_carry (res_carry),
        .res_zero  (res_zero),
        .res_ready (res_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic on plain integers, one operand at a time.
    function automatic void refStep(input int op, input int acc, input int d,
                                    output int nacc, output int ncarry);
        int s;
        ncarry = 0;
        case (op)
            0: nacc = acc & d;
            1: nacc = acc ^ d;
            2: begin
                s      = acc + d;
                nacc   = s % 256;
                ncarry = (s > 255) ? 1 : 0;
            end
            default: begin
                ncarry = (acc < d) ? 1 : 0;
                nacc   = (acc - d + 256) % 256;
            end
        endcase
    endfunction

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_op_ready"}, op_ready, 0);
        checkOutput({tag, "_res_valid"}, res_valid, 0);
        checkOutput({tag, "_res_data"}, res_data, 0);
        checkOutput({tag, "_res_carry"}, res_carry, 0);
        checkOutput({tag, "_res_zero"}, res_zero, 0);
        checkOutput({tag, "_busy"}, busy, 0);
    endtask

    // Entered at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic applyStimulus(input int op, input int initV, input int lenV,
                                 input int gap, input int hold, input bit injectStart);
        int expAcc;
        int expCarry;
        int nacc;
        int ncarry;
        opcode    = 2'(op);
        init      = 8'(initV);
        len       = 4'(lenV);
        start     = 1'b1;
        op_valid  = 1'b0;
        res_ready = 1'b0;
        checkOutput("idle_op_ready", op_ready, 0);
        checkOutput("idle_busy", busy, 0);
        expAcc   = initV;
        expCarry = 0;
        @(negedge clk);
        start  = injectStart;
        opcode = 2'(op) ^ 2'b11;
        init   = ~8'(initV);
        len    = 4'(lenV + 5);
        for (int i = 0; i < lenV; i++) begin
            for (int g = 0; g < gap; g++) begin
                checkOutput("stall_op_ready", op_ready, 1);
                checkOutput("stall_res_valid", res_valid, 0);
                @(negedge clk);
            end
            checkOutput("run_op_ready", op_ready, 1);
            checkOutput("run_busy", busy, 1);
            op_valid = 1'b1;
            op_data  = 8'(opsArr[i]);
            refStep(op, expAcc, opsArr[i], nacc, ncarry);
            expAcc   = nacc;
            expCarry = ncarry;
            @(negedge clk);
            op_valid = 1'b0;
        end
        for (int h = 0; h <= hold; h++) begin
            checkOutput("done_res_valid", res_valid, 1);
            checkOutput("done_op_ready", op_ready, 0);
            checkOutput("done_busy", busy, 1);
            checkOutput("done_res_data", res_data, expAcc);
            checkOutput("done_res_carry", res_carry, expCarry);
            checkOutput("done_res_zero", res_zero, (expAcc == 0) ? 1 : 0);
            if (h == hold) begin
                res_ready = 1'b1;
            end else begin
                op_valid = 1'b1;
                op_data  = 8'($urandom);
                @(negedge clk);
                op_valid = 1'b0;
            end
        end
        lastObsData  = int'(res_data);
        lastObsCarry = int'(res_carry);
        lastObsZero  = int'(res_zero);
        @(negedge clk);
        res_ready = 1'b0;
        start     = 1'b0;
        checkOutput("post_res_valid", res_valid, 0);
        checkOutput("post_busy", busy, 0);
        checkOutput("post_op_ready", op_ready, 0);
    endtask

    initial begin
        int rOp;
        int rInit;
        int rLen;
        rst_n     = 1'b0;
        start     = 1'b0;
        opcode    = 2'b00;
        init      = '0;
        len       = '0;
        op_valid  = 1'b0;
        op_data   = '0;
        res_ready = 1'b0;
        $display("[TB] reset phase");
        repeat (2) @(negedge clk);
        checkAllZero("reset");
        rst_n = 1'b1;

        // Start driven in the very first cycle after reset release.
        opsArr[0] = 'h01; opsArr[1] = 'h02; opsArr[2] = 'h03;
        applyStimulus(2, 'h10, 3, 0, 0, 1'b0);
        checkOutput("add3_data", lastObsData, 'h16);
        checkOutput("add3_carry", lastObsCarry, 0);
        checkOutput("add3_zero", lastObsZero, 0);

        opsArr[0] = 'h20;
        applyStimulus(2, 'hF0, 1, 0, 0, 1'b0);
        checkOutput("addc_data", lastObsData, 'h10);
        checkOutput("addc_carry", lastObsCarry, 1);

        opsArr[0] = 'h05;
        applyStimulus(3, 'h05, 1, 0, 0, 1'b0);
        checkOutput("subz_data", lastObsData, 'h00);
        checkOutput("subz_zero", lastObsZero, 1);
        checkOutput("subz_carry", lastObsCarry, 0);

        opsArr[0] = 'h04;
        applyStimulus(3, 'h03, 1, 0, 0, 1'b0);
        checkOutput("subb_data", lastObsData, 'hFF);
        checkOutput("subb_carry", lastObsCarry, 1);

        opsArr[0] = 'hFF; opsArr[1] = 'h0F;
        applyStimulus(1, 'hAA, 2, 3, 5, 1'b0);
        checkOutput("xor_data", lastObsData, 'h5A);

        applyStimulus(0, 'h3C, 0, 0, 1, 1'b0);
        checkOutput("len0_data", lastObsData, 'h3C);
        checkOutput("len0_carry", lastObsCarry, 0);

        opsArr[0] = 'h11; opsArr[1] = 'h22; opsArr[2] = 'h33;
        applyStimulus(2, 'h01, 3, 1, 2, 1'b1);
        checkOutput("inject_data", lastObsData, 'h67);

        $display("[TB] mid-run reset");
        start = 1'b1; opcode = 2'b10; init = 8'h10; len = 4'd4;
        @(negedge clk);
        start = 1'b0; op_valid = 1'b1; op_data = 8'h01;
        @(negedge clk);
        op_data = 8'h02;
        @(negedge clk);
        op_valid = 1'b0;
        checkOutput("pre_reset_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1 checkAllZero("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            op_valid  = 1'b1;
            op_data   = 8'($urandom);
            res_ready = 1'b1;
            @(negedge clk);
            checkOutput("after_reset_res_valid", res_valid, 0);
            checkOutput("after_reset_busy", busy, 0);
        end
        op_valid  = 1'b0;
        res_ready = 1'b0;
        opsArr[0] = 'h04; opsArr[1] = 'h08; opsArr[2] = 'h10; opsArr[3] = 'h20;
        applyStimulus(2, 'h01, 4, 0, 0, 1'b0);
        checkOutput("after_reset_job", lastObsData, 'h3D);

        $display("[TB] reset in DONE");
        start = 1'b1; opcode = 2'b01; init = 8'h77; len = 4'd0;
        @(negedge clk);
        start = 1'b0;
        checkOutput("pre_reset_done_valid", res_valid, 1);
        #2 rst_n = 1'b0;
        #1 checkAllZero("done_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("done_reset_no_result", res_valid, 0);

        $display("[TB] random jobs");
        for (int j = 0; j < 24; j++) begin
            rOp   = int'($urandom_range(0, 3));
            rInit = int'($urandom_range(0, 255));
            rLen  = int'($urandom_range(0, 15));
            for (int k = 0; k < 16; k++) begin
                opsArr[k] = int'($urandom_range(0, 255));
            end
            applyStimulus(rOp, rInit, rLen, int'($urandom_range(0, 2)),
                          int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
